// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the BCD 7-segment display driver:
//   SEG_BLANK / SEG_DASH   active-low patterns for an unlit digit and a dash
//   SEG_DIGIT[0:9]         active-low patterns for decimal digits, DP off
//   state_e                conversion FSM states
//   add3()                 double-dabble nibble correction
// -----------------------------------------------------------------------------
package seg7_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   localparam logic [7:0] SEG_DIGIT [0:9] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_e;

   // A nibble of 5 or more would become >= 10 after the next shift, so it is
   // pre-corrected by 3 to carry into the next decimal digit instead.
   function automatic logic [3:0] add3(input logic [3:0] nibble);
      logic [3:0] res;
      if (nibble >= 4'd5) begin
         res = nibble + 4'd3;
      end else begin
         res = nibble;
      end
      return res;
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// -----------------------------------------------------------------------------
// seg7_encode
// Combinational BCD nibble to active-low 7-segment pattern (bit7 = DP, off).
//   nibble_i  in   4   BCD digit; values above 9 render blank
//   blank_i   in   1   force the digit dark
//   seg_o     out  8   active-low segment pattern
// -----------------------------------------------------------------------------
module seg7_encode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       blank_i,
   output logic [7:0] seg_o
);

   // Pattern lookup with blanking taking priority.
   always_comb begin
      seg_o = SEG_BLANK;
      if (blank_i) begin
         seg_o = SEG_BLANK;
      end else begin
         case (nibble_i)
            4'd0:    seg_o = SEG_DIGIT[0];
            4'd1:    seg_o = SEG_DIGIT[1];
            4'd2:    seg_o = SEG_DIGIT[2];
            4'd3:    seg_o = SEG_DIGIT[3];
            4'd4:    seg_o = SEG_DIGIT[4];
            4'd5:    seg_o = SEG_DIGIT[5];
            4'd6:    seg_o = SEG_DIGIT[6];
            4'd7:    seg_o = SEG_DIGIT[7];
            4'd8:    seg_o = SEG_DIGIT[8];
            4'd9:    seg_o = SEG_DIGIT[9];
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/bcd_seg_display.sv
// -----------------------------------------------------------------------------
// bcd_seg_display
// Binary to decimal 7-segment driver. A value accepted on start is converted
// by a one-bit-per-clock double-dabble engine, encoded to active-low patterns
// and presented both per digit and time-multiplexed for common-anode scanning.
//   clk      in   1          rising-edge clock
//   rst      in   1          synchronous reset, active-high
//   start    in   1          conversion request, honoured in IDLE only
//   bin      in   BIN_W      unsigned value sampled when start is accepted
//   busy     out  1          conversion in progress (CONV / DONE)
//   done     out  1          one-cycle pulse when bcd/seg_par/ovf update
//   ovf      out  1          value did not fit in DIGITS decimal digits
//   bcd      out  4*DIGITS   BCD digits, digit 0 in [3:0]
//   seg_par  out  8*DIGITS   per-digit patterns, digit 0 in [7:0]
//   seg_mux  out  8          pattern of the digit currently scanned
//   an_n     out  DIGITS     one-hot active-low digit enable
// -----------------------------------------------------------------------------
module bcd_seg_display
   import seg7_pkg::*;
#(
   parameter int BIN_W    = 8,
   parameter int DIGITS   = 3,
   parameter int BLANK_LZ = 1,
   parameter int SCAN_DIV = 1000
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [8*DIGITS-1:0]   seg_par,
   output logic [7:0]            seg_mux,
   output logic [DIGITS-1:0]     an_n
);

   // One spare nibble above the displayed digits catches overflow.
   localparam int BCD_W = 4 * DIGITS + 4;
   localparam int SH_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SCW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIN_W - 1);
   localparam logic [SCW-1:0]   SCAN_LAST = SCW'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

   if (BIN_W < 1 || BIN_W > 32) begin : g_bad_bin_w
      $error("bcd_seg_display: BIN_W must be 1..32");
   end
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("bcd_seg_display: DIGITS must be 1..8");
   end
   if (SCAN_DIV < 1) begin : g_bad_scan_div
      $error("bcd_seg_display: SCAN_DIV must be >= 1");
   end

   state_e                state_q, state_d;
   logic [SH_W-1:0]       sh_q, sh_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BCD_W-1:0]      dab_s;
   logic [SH_W-1:0]       pre_s;
   logic [BCD_W-1:0]      res_s;
   logic                  ovf_s;
   logic [DIGITS-1:0]     blank_s;
   logic [8*DIGITS-1:0]   enc_s;
   logic [8*DIGITS-1:0]   seg_next_s;

   logic                  busy_q, done_q, ovf_q;
   logic [4*DIGITS-1:0]   bcd_q;
   logic [8*DIGITS-1:0]   seg_par_q;
   logic [SCW-1:0]        scnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [IDX_W-1:0]      idx_nx_s;
   logic [7:0]            seg_mux_q;
   logic [DIGITS-1:0]     an_n_q;

   // Add-3 correction applied to every BCD nibble ahead of the shift.
   always_comb begin
      dab_s = sh_q[BIN_W +: BCD_W];
      for (int i = 0; i < DIGITS + 1; i++) begin
         dab_s[4*i +: 4] = add3(sh_q[BIN_W + 4*i +: 4]);
      end
      pre_s = {dab_s, sh_q[BIN_W-1:0]};
   end

   // Conversion FSM: load, BIN_W correct-and-shift steps, then publish.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = {{BCD_W{1'b0}}, bin};
               cnt_d   = {CNT_W{1'b0}};
               state_d = CONV;
            end else begin
               state_d = IDLE;
            end
         end
         CONV: begin
            sh_d  = pre_s << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               state_d = CONV;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Result decode: overflow nibble and leading-zero blanking mask.
   always_comb begin
      logic hi_zero;
      res_s   = sh_q[BIN_W +: BCD_W];
      ovf_s   = |res_s[BCD_W-1 -: 4];
      blank_s = {DIGITS{1'b0}};
      hi_zero = 1'b1;
      // Walk from the most significant digit down so hi_zero means
      // "this digit and everything above it is zero".
      for (int i = DIGITS - 1; i >= 0; i--) begin
         hi_zero = hi_zero & (res_s[4*i +: 4] == 4'd0);
         if ((BLANK_LZ != 0) && (i > 0) && hi_zero && !ovf_s) begin
            blank_s[i] = 1'b1;
         end else begin
            blank_s[i] = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_enc
      seg7_encode u_enc (
         .nibble_i (res_s[4*g +: 4]),
         .blank_i  (blank_s[g]),
         .seg_o    (enc_s[8*g +: 8])
      );
   end

   // Overflow replaces every digit with a dash.
   always_comb begin
      if (ovf_s) begin
         seg_next_s = {DIGITS{SEG_DASH}};
      end else begin
         seg_next_s = enc_s;
      end
   end

   // FSM state, datapath and published results.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         sh_q      <= {SH_W{1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         bcd_q     <= {(4*DIGITS){1'b0}};
         seg_par_q <= {DIGITS{SEG_BLANK}};
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_q == DONE);
         if (state_q == DONE) begin
            bcd_q     <= res_s[4*DIGITS-1:0];
            seg_par_q <= seg_next_s;
            ovf_q     <= ovf_s;
         end
      end
   end

   // Next scanned digit index, wrapping after the last digit.
   always_comb begin
      if (idx_q == IDX_LAST) begin
         idx_nx_s = {IDX_W{1'b0}};
      end else begin
         idx_nx_s = idx_q + IDX_W'(1);
      end
   end

   // Free-running scan: anode and pattern move together at each wrap, so a
   // fresh seg_par appears on the display only at the next digit step.
   always_ff @(posedge clk) begin
      if (rst) begin
         scnt_q    <= {SCW{1'b0}};
         idx_q     <= {IDX_W{1'b0}};
         an_n_q    <= ~DIGITS'(1'b1);
         seg_mux_q <= SEG_BLANK;
      end else if (scnt_q == SCAN_LAST) begin
         scnt_q    <= {SCW{1'b0}};
         idx_q     <= idx_nx_s;
         an_n_q    <= ~(DIGITS'(1'b1) << idx_nx_s);
         seg_mux_q <= seg_par_q[8*idx_nx_s +: 8];
      end else begin
         scnt_q    <= scnt_q + SCW'(1);
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign ovf     = ovf_q;
   assign bcd     = bcd_q;
   assign seg_par = seg_par_q;
   assign seg_mux = seg_mux_q;
   assign an_n    = an_n_q;

endmodule
